// File: rtl/qs_srt_stack.sv
// Multi-bank LIFO stack for qs sort PUSH/POP and CALL/RET; pop response registered (1 cycle).
// cmd_rdy drops while an unconsumed response is held; define QS_SRT_STACK_XCHG_EN for push+pop exchange.
module qs_srt_stack #(
    parameter int W       = 8,
    parameter int N       = 16,
    parameter int BANKS_N = 4,
    localparam int BW     = (BANKS_N > 1) ? $clog2(BANKS_N) : 1,
    localparam int PW     = $clog2(N) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_vld,
    input  logic [BW-1:0]      cmd_bank,
    input  logic               cmd_push,
    input  logic               cmd_pop,
    input  logic [W-1:0]       cmd_data,
    output logic               cmd_rdy,
    output logic               rsp_vld,
    output logic [BW-1:0]      rsp_bank,
    output logic [W-1:0]       rsp_data,
    input  logic               rsp_rdy,
    input  logic               flush,
    input  logic [BW-1:0]      flush_bank,
    output logic [BANKS_N-1:0] empty_r,
    output logic [BANKS_N-1:0] full_r,
    output logic               err_ovf_r,
    output logic               err_unf_r,
    output logic               err_cmd_r
);

    localparam int AW = $clog2(N);
    localparam logic [PW-1:0] PTR_FULL = PW'(N);

    logic [W-1:0]       mem_q [BANKS_N][N];
    logic [PW-1:0]      ptr_q [BANKS_N];
    logic [PW-1:0]      ptr_d [BANKS_N];
    logic [BANKS_N-1:0] empty_q, empty_d, full_q, full_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [BW-1:0]      rsp_bank_q, rsp_bank_d;
    logic [W-1:0]       rsp_data_q, rsp_data_d;
    logic               err_ovf_q, err_ovf_d, err_unf_q, err_unf_d, err_cmd_q, err_cmd_d;

    logic               cmd_acc, cmd_live;
    logic [PW-1:0]      top, top_m1;
    logic [W-1:0]       top_data;
    logic               wr_en;
    logic [AW-1:0]      wr_idx;

    assign cmd_rdy = !rsp_vld_q | rsp_rdy;

    always_comb begin
        cmd_acc    = cmd_vld & cmd_rdy;
        // A flush of the addressed bank swallows the command: handshake completes, nothing else happens.
        cmd_live   = cmd_acc & !(flush && (flush_bank == cmd_bank));
        top        = ptr_q[cmd_bank];
        top_m1     = top - PW'(1);
        top_data   = mem_q[cmd_bank][top_m1[AW-1:0]];
        wr_en      = 1'b0;
        wr_idx     = top[AW-1:0];
        rsp_vld_d  = rsp_vld_q & !rsp_rdy;
        rsp_bank_d = rsp_bank_q;
        rsp_data_d = rsp_data_q;
        err_ovf_d  = err_ovf_q;
        err_unf_d  = err_unf_q;
        err_cmd_d  = err_cmd_q;
        for (int b = 0; b < BANKS_N; b++) ptr_d[b] = ptr_q[b];

        if (cmd_live) begin
            if (cmd_push && !cmd_pop) begin
                if (top == PTR_FULL) begin
                    err_ovf_d = 1'b1;
                end else begin
                    wr_en           = 1'b1;
                    ptr_d[cmd_bank] = top + PW'(1);
                end
            end else if (cmd_pop && !cmd_push) begin
                rsp_vld_d  = 1'b1;
                rsp_bank_d = cmd_bank;
                if (top == '0) begin
                    rsp_data_d = '0;
                    err_unf_d  = 1'b1;
                end else begin
                    rsp_data_d      = top_data;
                    ptr_d[cmd_bank] = top_m1;
                end
            end else if (cmd_push && cmd_pop) begin
`ifdef QS_SRT_STACK_XCHG_EN
                rsp_vld_d  = 1'b1;
                rsp_bank_d = cmd_bank;
                if (top == '0) begin
                    rsp_data_d = cmd_data;
                end else begin
                    rsp_data_d = top_data;
                    wr_en      = 1'b1;
                    wr_idx     = top_m1[AW-1:0];
                end
`else
                err_cmd_d = 1'b1;
`endif
            end
        end

        if (flush) ptr_d[flush_bank] = '0;
        for (int b = 0; b < BANKS_N; b++) begin
            empty_d[b] = (ptr_d[b] == '0);
            full_d[b]  = (ptr_d[b] == PTR_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BANKS_N; b++) ptr_q[b] <= '0;
            empty_q    <= '1;
            full_q     <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_bank_q <= '0;
            rsp_data_q <= '0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
            err_cmd_q  <= 1'b0;
        end else begin
            for (int b = 0; b < BANKS_N; b++) ptr_q[b] <= ptr_d[b];
            empty_q    <= empty_d;
            full_q     <= full_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_bank_q <= rsp_bank_d;
            rsp_data_q <= rsp_data_d;
            err_ovf_q  <= err_ovf_d;
            err_unf_q  <= err_unf_d;
            err_cmd_q  <= err_cmd_d;
        end
    end

    // Storage carries no reset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[cmd_bank][wr_idx] <= cmd_data;
    end

    assign rsp_vld   = rsp_vld_q;
    assign rsp_bank  = rsp_bank_q;
    assign rsp_data  = rsp_data_q;
    assign empty_r   = empty_q;
    assign full_r    = full_q;
    assign err_ovf_r = err_ovf_q;
    assign err_unf_r = err_unf_q;
    assign err_cmd_r = err_cmd_q;

endmodule

// File: tb/tb_qs_srt_stack.sv
// Directed bench for qs_srt_stack (W=8, N=16, BANKS_N=4); honours QS_SRT_STACK_XCHG_EN.
module tb_qs_srt_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_vld;
    logic [1:0] cmd_bank;
    logic       cmd_push;
    logic       cmd_pop;
    logic [7:0] cmd_data;
    logic       cmd_rdy;
    logic       rsp_vld;
    logic [1:0] rsp_bank;
    logic [7:0] rsp_data;
    logic       rsp_rdy;
    logic       flush;
    logic [1:0] flush_bank;
    logic [3:0] empty_r;
    logic [3:0] full_r;
    logic       err_ovf_r;
    logic       err_unf_r;
    logic       err_cmd_r;

    int n_checks = 0;
    int n_fail   = 0;

    qs_srt_stack #(.W(8), .N(16), .BANKS_N(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_bank(cmd_bank), .cmd_push(cmd_push), .cmd_pop(cmd_pop),
        .cmd_data(cmd_data), .cmd_rdy(cmd_rdy),
        .rsp_vld(rsp_vld), .rsp_bank(rsp_bank), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy),
        .flush(flush), .flush_bank(flush_bank),
        .empty_r(empty_r), .full_r(full_r),
        .err_ovf_r(err_ovf_r), .err_unf_r(err_unf_r), .err_cmd_r(err_cmd_r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd_vld = 1'b0; cmd_push = 1'b0; cmd_pop = 1'b0; flush = 1'b0;
    endtask

    task automatic drive(input logic [1:0] b, input logic psh, input logic pp, input logic [7:0] d);
        cmd_vld = 1'b1; cmd_bank = b; cmd_push = psh; cmd_pop = pp; cmd_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); cmd_bank = '0; cmd_data = '0; rsp_rdy = 1'b1; flush_bank = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_checks++; if (empty_r !== 4'hF) begin n_fail++; $display("FAIL reset_empty got %h exp %h", empty_r, 4'hF); end
        n_checks++; if (full_r !== 4'h0) begin n_fail++; $display("FAIL reset_full got %h exp %h", full_r, 4'h0); end
        n_checks++; if ({rsp_vld, rsp_bank, rsp_data} !== 11'h0) begin n_fail++; $display("FAIL reset_rsp got %b/%h/%h exp 0/0/0", rsp_vld, rsp_bank, rsp_data); end
        n_checks++; if ({err_ovf_r, err_unf_r, err_cmd_r} !== 3'b000) begin n_fail++; $display("FAIL reset_err got %b exp 000", {err_ovf_r, err_unf_r, err_cmd_r}); end
        n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_rdy got %b exp 1", cmd_rdy); end
    endtask

    task automatic test_lifo();
        logic [7:0] exp_q[3];
        exp_q[0] = 8'h33; exp_q[1] = 8'h22; exp_q[2] = 8'h11;
        drive(2'd2, 1'b1, 1'b0, 8'h11); tick();
        drive(2'd2, 1'b1, 1'b0, 8'h22); tick();
        drive(2'd2, 1'b1, 1'b0, 8'h33); tick();
        n_checks++; if (empty_r !== 4'b1011) begin n_fail++; $display("FAIL lifo_nonempty got %b exp 1011", empty_r); end
        drive(2'd2, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) idle();
            n_checks++;
            if ({rsp_vld, rsp_bank, rsp_data} !== {1'b1, 2'd2, exp_q[i]}) begin
                n_fail++; $display("FAIL lifo_pop%0d got %b/%0d/%h exp 1/2/%h", i, rsp_vld, rsp_bank, rsp_data, exp_q[i]);
            end
        end
        tick();
        n_checks++; if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL lifo_drain got %b exp 0", rsp_vld); end
        n_checks++; if (empty_r[2] !== 1'b1) begin n_fail++; $display("FAIL lifo_empty got %b exp 1", empty_r[2]); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive(2'd0, 1'b1, 1'b0, 8'(i + 1)); tick();
        end
        n_checks++; if (full_r !== 4'b0001) begin n_fail++; $display("FAIL full_set got %b exp 0001", full_r); end
        n_checks++; if (err_ovf_r !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf got %b exp 0", err_ovf_r); end
        drive(2'd0, 1'b1, 1'b0, 8'hAA); tick();
        n_checks++; if (err_ovf_r !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", err_ovf_r); end
        drive(2'd0, 1'b0, 1'b1, 8'h00); tick(); idle();
        n_checks++; if (rsp_data !== 8'h10) begin n_fail++; $display("FAIL ovf_pop got %h exp 10", rsp_data); end
        n_checks++; if (full_r[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_notfull got %b exp 0", full_r[0]); end
        flush = 1'b1; flush_bank = 2'd0; tick(); idle();
        n_checks++; if (empty_r !== 4'hF) begin n_fail++; $display("FAIL flush0_empty got %b exp 1111", empty_r); end
        n_checks++; if (err_ovf_r !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", err_ovf_r); end
    endtask

    task automatic test_underflow();
        drive(2'd1, 1'b0, 1'b1, 8'h5A); tick(); idle();
        n_checks++; if ({rsp_vld, rsp_bank, rsp_data} !== {1'b1, 2'd1, 8'h00}) begin n_fail++; $display("FAIL unf_rsp got %b/%0d/%h exp 1/1/00", rsp_vld, rsp_bank, rsp_data); end
        n_checks++; if (err_unf_r !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b exp 1", err_unf_r); end
        n_checks++; if (empty_r !== 4'hF) begin n_fail++; $display("FAIL unf_ptr got %b exp 1111", empty_r); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(2'd1, 1'b1, 1'b0, 8'h41); tick();
        drive(2'd1, 1'b1, 1'b0, 8'h42); tick();
        rsp_rdy = 1'b0;
        drive(2'd1, 1'b0, 1'b1, 8'h00); tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({rsp_vld, rsp_data} !== {1'b1, 8'h42}) begin n_fail++; $display("FAIL bp_hold%0d got %b/%h exp 1/42", i, rsp_vld, rsp_data); end
            n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy%0d got %b exp 0", i, cmd_rdy); end
            if (i < 2) tick();
        end
        rsp_rdy = 1'b1; #1;
        n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b exp 1", cmd_rdy); end
        tick(); idle();
        n_checks++; if ({rsp_vld, rsp_bank, rsp_data} !== {1'b1, 2'd1, 8'h41}) begin n_fail++; $display("FAIL bp_second got %b/%0d/%h exp 1/1/41", rsp_vld, rsp_bank, rsp_data); end
        tick();
        n_checks++; if ({rsp_vld, empty_r[1]} !== 2'b01) begin n_fail++; $display("FAIL bp_done got %b exp 01", {rsp_vld, empty_r[1]}); end
    endtask

    task automatic test_flush();
        drive(2'd3, 1'b1, 1'b0, 8'h66); tick();
        n_checks++; if (empty_r[3] !== 1'b0) begin n_fail++; $display("FAIL fl_pre got %b exp 0", empty_r[3]); end
        flush = 1'b1; flush_bank = 2'd3;
        drive(2'd3, 1'b1, 1'b0, 8'h77); tick();
        n_checks++; if ({empty_r[3], rsp_vld} !== 2'b10) begin n_fail++; $display("FAIL fl_same got %b exp 10", {empty_r[3], rsp_vld}); end
        drive(2'd0, 1'b1, 1'b0, 8'h05); tick(); idle();
        n_checks++; if ({empty_r, rsp_vld} !== 5'b1110_0) begin n_fail++; $display("FAIL fl_other got %b exp 11100", {empty_r, rsp_vld}); end
        drive(2'd0, 1'b0, 1'b1, 8'h00); tick(); idle();
        n_checks++; if ({rsp_vld, rsp_data, empty_r[0]} !== {1'b1, 8'h05, 1'b1}) begin n_fail++; $display("FAIL fl_pop got %b/%h/%b exp 1/05/1", rsp_vld, rsp_data, empty_r[0]); end
        tick();
    endtask

    task automatic test_xchg();
        drive(2'd0, 1'b1, 1'b0, 8'h07); tick();
        drive(2'd0, 1'b1, 1'b1, 8'h09); tick(); idle();
`ifdef QS_SRT_STACK_XCHG_EN
        n_checks++; if ({rsp_vld, rsp_data, err_cmd_r} !== {1'b1, 8'h07, 1'b0}) begin n_fail++; $display("FAIL xchg_rsp got %b/%h/%b exp 1/07/0", rsp_vld, rsp_data, err_cmd_r); end
        tick();
        drive(2'd0, 1'b0, 1'b1, 8'h00); tick(); idle();
        n_checks++; if ({rsp_vld, rsp_data} !== {1'b1, 8'h09}) begin n_fail++; $display("FAIL xchg_next got %b/%h exp 1/09", rsp_vld, rsp_data); end
`else
        n_checks++; if ({rsp_vld, err_cmd_r} !== 2'b01) begin n_fail++; $display("FAIL cmd_err got %b exp 01", {rsp_vld, err_cmd_r}); end
        drive(2'd0, 1'b0, 1'b1, 8'h00); tick(); idle();
        n_checks++; if ({rsp_vld, rsp_data} !== {1'b1, 8'h07}) begin n_fail++; $display("FAIL cmd_next got %b/%h exp 1/07", rsp_vld, rsp_data); end
`endif
        n_checks++; if (empty_r[0] !== 1'b1) begin n_fail++; $display("FAIL xchg_empty got %b exp 1", empty_r[0]); end
    endtask

    task automatic test_mid_reset();
        drive(2'd2, 1'b1, 1'b0, 8'hC3); tick();
        drive(2'd2, 1'b0, 1'b1, 8'h00); rsp_rdy = 1'b0; tick(); idle();
        n_checks++; if ({rsp_vld, rsp_data} !== {1'b1, 8'hC3}) begin n_fail++; $display("FAIL mr_pre got %b/%h exp 1/c3", rsp_vld, rsp_data); end
        drive(2'd1, 1'b1, 1'b0, 8'h12); rsp_rdy = 1'b1; tick();
        rst = 1'b1; idle(); tick(); rst = 1'b0;
        n_checks++; if ({empty_r, full_r} !== 8'hF0) begin n_fail++; $display("FAIL mr_status got %h exp f0", {empty_r, full_r}); end
        n_checks++; if ({rsp_vld, rsp_bank, rsp_data} !== 11'h0) begin n_fail++; $display("FAIL mr_rsp got %b/%h/%h exp 0/0/0", rsp_vld, rsp_bank, rsp_data); end
        n_checks++; if ({err_ovf_r, err_unf_r, err_cmd_r} !== 3'b000) begin n_fail++; $display("FAIL mr_err got %b exp 000", {err_ovf_r, err_unf_r, err_cmd_r}); end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_full();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_xchg();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
